// File: rtl/vga_sync_generator_pkg.sv
// rtl/vga_sync_generator_pkg.sv - shared 640x480@60 timing defaults and helpers
package vga_sync_generator_pkg;

  // 640x480@60 with a 50 MHz system clock and a 25 MHz pixel rate
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_SYNC_POL  = 0;

  // Raster counters are 10 bits wide, so totals must stay <= 1024
  localparam int CNT_W = 10;

  // Inclusive range test used for the sync pulse windows
  function automatic logic in_range(input logic [CNT_W-1:0] val, input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// rtl/vga_pixel_tick.sv - system-clock to pixel-rate divider with freeze
module vga_pixel_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic pixel_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Divider counts only while enabled, so a freeze resumes from the held phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Reset gates the decode so the tick is low while reset is held, even with CLK_DIV=1
  assign pixel_tick = reset & enable & (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - VGA raster counters, sync pulses and video window
module vga_sync_generator
  import vga_sync_generator_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int SYNC_POL  = DEF_SYNC_POL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             pixel_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam logic SYNC_ACT = 1'(SYNC_POL);

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_last;
  logic             v_last;
  logic             frame_wrap;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pixel_tick (pixel_tick)
  );

  // Next raster position: advance one pixel per tick, wrapping line then frame
  always_comb begin
    h_last     = (pixel_x == CNT_W'(H_TOTAL - 1));
    v_last     = (pixel_y == CNT_W'(V_TOTAL - 1));
    h_next     = pixel_x;
    v_next     = pixel_y;
    frame_wrap = pixel_tick & h_last & v_last;
    if (pixel_tick) begin
      if (h_last) begin
        h_next = '0;
        v_next = v_last ? '0 : pixel_y + CNT_W'(1);
      end else begin
        h_next = pixel_x + CNT_W'(1);
      end
    end
  end

  // Counters and decodes register together from the next position, so they never skew
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b1;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      frame_start <= 1'b0;
    end else if (enable) begin
      pixel_x     <= h_next;
      pixel_y     <= v_next;
      video_on    <= (h_next < CNT_W'(H_DISPLAY)) && (v_next < CNT_W'(V_DISPLAY));
      hsync       <= in_range(h_next, HS_START, HS_END) ? SYNC_ACT : ~SYNC_ACT;
      vsync       <= in_range(v_next, VS_START, VS_END) ? SYNC_ACT : ~SYNC_ACT;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - self-checking bench for vga_sync_generator
module tb_vga_sync_generator;

  // Scaled-down raster so whole frames fit in a short run
  localparam int CLK_DIV = 2;
  localparam int HD = 40, HF = 4, HS = 6, HB = 5;
  localparam int VD = 30, VF = 3, VS = 2, VB = 4;
  localparam int SP = 0;
  localparam int H_TOTAL = HD + HF + HS + HB;
  localparam int V_TOTAL = VD + VF + VS + VB;
  localparam int FRAME = H_TOTAL * V_TOTAL;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       pixel_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: enabled clocks since reset, pixels elapsed since reset
  int en_cnt = 0;
  int ticks = 0;
  int tick_at = -1;

  vga_sync_generator #(
    .CLK_DIV(CLK_DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(SP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_cnt  <= 0;
      ticks   <= 0;
      tick_at <= -1;
    end else if (enable) begin
      en_cnt <= en_cnt + 1;
      if (en_cnt % CLK_DIV == CLK_DIV - 1) begin
        ticks   <= ticks + 1;
        tick_at <= en_cnt + 1;
      end
    end
  end

  function automatic int exp_vec();
    int x, y, von, hs, vs, fs, tk;
    x   = ticks % H_TOTAL;
    y   = (ticks / H_TOTAL) % V_TOTAL;
    von = (x < HD && y < VD) ? 1 : 0;
    hs  = (x >= HD + HF && x < HD + HF + HS) ? SP : 1 - SP;
    vs  = (y >= VD + VF && y < VD + VF + VS) ? SP : 1 - SP;
    fs  = (ticks > 0 && ticks % FRAME == 0 && tick_at == en_cnt) ? 1 : 0;
    tk  = (reset && enable && (en_cnt % CLK_DIV == CLK_DIV - 1)) ? 1 : 0;
    return (tk << 24) | (x << 14) | (y << 4) | (von << 3) | (hs << 2) | (vs << 1) | fs;
  endfunction

  function automatic int act_vec();
    return (int'(pixel_tick) << 24) | (int'(pixel_x) << 14) | (int'(pixel_y) << 4) |
           (int'(video_on) << 3) | (int'(hsync) << 2) | (int'(vsync) << 1) | int'(frame_start);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic check_model();
    int e, a;
    e = exp_vec();
    a = act_vec();
    total_cnt++;
    if (a == e) pass_cnt++;
    else $display("FAIL model t=%0t: actual tick/x/y/von/hs/vs/fs=%0d/%0d/%0d/%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d/%0d/%0d/%0d",
                  $time, a[24], a[23:14], a[13:4], a[3], a[2], a[1], a[0],
                  e[24], e[23:14], e[13:4], e[3], e[2], e[1], e[0]);
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
  endtask

  task automatic goto_tick(input int target, input string name);
    int guard;
    guard = 0;
    while (ticks < target && guard < 4 * FRAME * CLK_DIV) begin
      step();
      guard++;
    end
    if (ticks != target) begin
      total_cnt++;
      $display("FAIL %s timeout: actual ticks=%0d required=%0d", name, ticks, target);
    end
  endtask

  typedef struct {
    int x;
    int y;
    int von;
    int hs;
    int vs;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int hs_low, vs_low, fs_cnt, hold_ok, base;

    vecs[0]  = '{1, 0, 1, 1, 1};
    vecs[1]  = '{39, 0, 1, 1, 1};
    vecs[2]  = '{40, 0, 0, 1, 1};
    vecs[3]  = '{43, 0, 0, 1, 1};
    vecs[4]  = '{44, 0, 0, 0, 1};
    vecs[5]  = '{49, 0, 0, 0, 1};
    vecs[6]  = '{50, 0, 0, 1, 1};
    vecs[7]  = '{54, 0, 0, 1, 1};
    vecs[8]  = '{0, 1, 1, 1, 1};
    vecs[9]  = '{39, 29, 1, 1, 1};
    vecs[10] = '{40, 29, 0, 1, 1};
    vecs[11] = '{0, 30, 0, 1, 1};
    vecs[12] = '{0, 33, 0, 1, 0};
    vecs[13] = '{46, 34, 0, 0, 0};
    vecs[14] = '{0, 35, 0, 1, 1};
    vecs[15] = '{54, 38, 0, 1, 1};

    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (2) step();
    check("rst_x", pixel_x, 0);
    check("rst_y", pixel_y, 0);
    check("rst_video_on", video_on, 1);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_frame_start", frame_start, 0);
    check("rst_pixel_tick", pixel_tick, 0);

    reset = 1'b1;

    // Boundary positions across the first frame
    for (int i = 0; i < 16; i++) begin
      goto_tick(vecs[i].y * H_TOTAL + vecs[i].x, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_x", i), pixel_x, vecs[i].x);
      check($sformatf("vec%0d_y", i), pixel_y, vecs[i].y);
      check($sformatf("vec%0d_video_on", i), video_on, vecs[i].von);
      check($sformatf("vec%0d_hsync", i), hsync, vecs[i].hs);
      check($sformatf("vec%0d_vsync", i), vsync, vecs[i].vs);
    end

    // Frame wrap: (54,38) -> (0,0) with a one-clk frame_start
    goto_tick(FRAME, "wrap");
    check("wrap_x", pixel_x, 0);
    check("wrap_y", pixel_y, 0);
    check("wrap_video_on", video_on, 1);
    check("wrap_frame_start", frame_start, 1);
    step();
    check("wrap_frame_start_clear", frame_start, 0);

    // One full frame: count active sync positions and frame_start pulses
    hs_low = 0; vs_low = 0; fs_cnt = 0;
    for (int i = 0; i < FRAME * CLK_DIV - 1; i++) begin
      step();
      if (pixel_tick && hsync == 1'b0) hs_low++;
      if (pixel_tick && vsync == 1'b0) vs_low++;
      if (frame_start) fs_cnt++;
    end
    check("frame_hsync_ticks", hs_low, HS * V_TOTAL);
    check("frame_vsync_ticks", vs_low, VS * H_TOTAL);
    check("frame_start_pulses", fs_cnt, 1);

    // Freeze at (30,20) for 10 clks, then resume to (31,20)
    goto_tick(2 * FRAME + 20 * H_TOTAL + 30, "hold");
    enable = 1'b0;
    hold_ok = 1;
    repeat (10) begin
      step();
      if (pixel_tick !== 1'b0 || pixel_x !== 10'd30 || pixel_y !== 10'd20) hold_ok = 0;
    end
    check("hold_frozen", hold_ok, 1);
    enable = 1'b1;
    goto_tick(2 * FRAME + 20 * H_TOTAL + 31, "resume");
    check("resume_x", pixel_x, 31);
    check("resume_y", pixel_y, 20);

    // Random enable pattern checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      step();
    end
    enable = 1'b1;

    // Asynchronous reset mid-frame at (52,34), inside vsync
    base = ((ticks / FRAME) + 1) * FRAME;
    goto_tick(base + 34 * H_TOTAL + 52, "pre_reset");
    check("pre_reset_x", pixel_x, 52);
    check("pre_reset_vsync", vsync, 0);
    #2 reset = 1'b0;
    #1;
    check("async_x", pixel_x, 0);
    check("async_y", pixel_y, 0);
    check("async_hsync", hsync, 1);
    check("async_vsync", vsync, 1);
    check("async_video_on", video_on, 1);
    check("async_pixel_tick", pixel_tick, 0);
    step();
    reset = 1'b1;
    goto_tick(1, "post_reset");
    check("post_reset_x", pixel_x, 1);
    check("post_reset_y", pixel_y, 0);
    repeat (300) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
